// File: rtl/serial_mem_pkg.sv
// Shared definitions for the bit-serial circulating byte memory and its
// host-side loader: FSM state encoding, word size and default depth.
package serial_mem_pkg;

  localparam int BITS_PER_WORD      = 8;
  localparam int DEFAULT_WORD_COUNT = 32;

  // Loader FSM states. CHECK is only reachable when readback verification
  // is compiled in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    CHECK = 3'd4
  } state_t;

endpackage

// File: rtl/serial_mem_phase.sv
// Phase model of the circulating memory: a free-running bit counter within
// the byte period and the slot index currently passing the write window.
// It runs from the same clk/reset as the memory, so it stays in lockstep
// with it. Kept separate so a future reader block can reuse it.
module serial_mem_phase
  import serial_mem_pkg::*;
#(
  parameter int WORD_COUNT = DEFAULT_WORD_COUNT,
  parameter int AW         = $clog2(WORD_COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [2:0]    bit_cnt,
  output logic [AW-1:0] cur_slot
);

  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_WORD - 1);

  // Free-running phase: bit_cnt wraps every byte period, cur_slot advances
  // on each wrap and rolls over modulo WORD_COUNT through AW-bit arithmetic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= 3'd0;
      cur_slot <= '0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == LAST_BIT) begin
        cur_slot <= cur_slot + AW'(1);
      end
    end
  end

endmodule

// File: rtl/serial_mem_loader.sv
// Host-side writer for the bit-serial circulating byte memory.
// A (slot, byte) request is accepted over valid/ready, held until the target
// slot reaches the write window, then shifted out LSB-first over 8 cycles.
// Optional macro SERIAL_MEM_LOADER_VERIFY_EN adds a readback check of the
// written byte on mem_q with a sticky err flag.
//
// Handshake: a request transfers on the rising clk edge where req_valid and
// req_ready are both 1; req_addr/req_data are latched on that edge. req_ready
// is 1 only in IDLE, so at most one request is ever outstanding. The host must
// hold req_valid/req_addr/req_data stable until the transfer edge.
module serial_mem_loader
  import serial_mem_pkg::*;
#(
  parameter int WORD_COUNT = DEFAULT_WORD_COUNT,
  parameter int AW         = $clog2(WORD_COUNT),
  parameter int OUT_OFFSET = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_data,
  output logic          mem_write,
  output logic          mem_din,
  input  logic [7:0]    mem_q,
  output logic [AW-1:0] cur_slot,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_WORD - 1);

  state_t        state;
  state_t        state_next;
  logic [2:0]    bit_cnt;
  logic [AW-1:0] next_slot;
  logic [AW-1:0] addr_q;
  logic [7:0]    data_q;
  logic          xfer;
  logic          window_req;
  logic          window_q;
  logic          check_hit;

  serial_mem_phase #(
    .WORD_COUNT (WORD_COUNT),
    .AW         (AW)
  ) u_phase (
    .clk      (clk),
    .reset    (reset),
    .bit_cnt  (bit_cnt),
    .cur_slot (cur_slot)
  );

  assign next_slot = cur_slot + AW'(1);
  assign xfer      = req_valid & req_ready;
  // The next cycle opens the byte period of the slot in question.
  assign window_req = (bit_cnt == LAST_BIT) && (next_slot == req_addr);
  assign window_q   = (bit_cnt == LAST_BIT) && (next_slot == addr_q);

`ifdef SERIAL_MEM_LOADER_VERIFY_EN
  logic [AW-1:0] check_slot;

  // The written byte shows up on mem_q OUT_OFFSET byte periods after its
  // write window; with OUT_OFFSET=1 that is already the DONE cycle.
  assign check_slot = addr_q + AW'(OUT_OFFSET);
  assign check_hit  = ((state == DONE) || (state == CHECK)) &&
                      (cur_slot == check_slot) && (bit_cnt == 3'd0);

  // Sticky readback mismatch flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (check_hit && (mem_q != data_q)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_verify;

  assign check_hit     = 1'b0;
  assign err           = 1'b0;
  assign unused_verify = ^{mem_q, AW'(OUT_OFFSET)};
`endif

  // Request capture on the transfer edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (xfer) begin
      addr_q <= req_addr;
      data_q <= req_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; a request landing right before its window skips WAIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_next = window_req ? SHIFT : WAIT;
        end
      end
      WAIT: begin
        if (window_q) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE: begin
`ifdef SERIAL_MEM_LOADER_VERIFY_EN
        state_next = check_hit ? IDLE : CHECK;
`else
        state_next = IDLE;
`endif
      end
      CHECK: begin
        if (check_hit) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register; the memory samples mem_write
  // and mem_din on the edge that ends each SHIFT cycle.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state == WAIT) || (state == SHIFT);
    done      = (state == DONE);
    mem_write = (state == SHIFT);
    mem_din   = (state == SHIFT) ? data_q[bit_cnt] : 1'b0;
  end

endmodule

// File: tb/tb_serial_mem_loader.sv
// Directed bench for serial_mem_loader (WORD_COUNT=32). Includes a small
// circulating-memory model driving mem_q; the readback checks run only when
// SERIAL_MEM_LOADER_VERIFY_EN is defined.
module tb_serial_mem_loader;
  import serial_mem_pkg::*;

  localparam int WC = 32;
  localparam int AW = 5;
  localparam int OO = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_data;
  logic          mem_write;
  logic          mem_din;
  logic [7:0]    mem_q;
  logic [AW-1:0] cur_slot;
  logic          busy;
  logic          done;
  logic          err;

  int passed = 0;
  int total  = 0;

  // Clock and cycle counter (cycle 0 = first cycle after reset release).
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  serial_mem_loader #(
    .WORD_COUNT (WC),
    .AW         (AW),
    .OUT_OFFSET (OO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_write (mem_write),
    .mem_din   (mem_din),
    .mem_q     (mem_q),
    .cur_slot  (cur_slot),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Memory model: slot/bit derived from the cycle count.
  logic [7:0] mem [WC];
  logic [7:0] corrupt;
  int m_slot;
  int m_bit;
  always_comb begin
    m_slot = (cyc / 8) % WC;
    m_bit  = cyc % 8;
  end
  always @(posedge clk) begin
    if (!reset && mem_write) mem[m_slot][m_bit] <= mem_din;
  end
  always_comb mem_q = mem[(m_slot - OO + WC) % WC] ^ corrupt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  // Wait (bounded) for the write strobe, then check start cycle, the 8 bits
  // LSB-first, the done pulse and its end.
  task automatic expect_write(input string tag, input logic [7:0] d, input int start);
    int n = 0;
    while (!mem_write && n < 700) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, cyc, start);
    for (int b = 0; b < 8; b++) begin
      chk({tag, "_we"}, mem_write, 1);
      chk({tag, "_din"}, mem_din, d[b]);
      tick();
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_we_off"}, mem_write, 0);
    chk({tag, "_busy_off"}, busy, 0);
    tick();
    chk({tag, "_done_end"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    corrupt   = 8'h00;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;

    // Reset values, during and right after reset.
    reset = 1'b1;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", mem_write, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_slot", cur_slot, 0);
    do_reset();

    // Idle rotation: slot steps every 8 cycles, no writes.
    for (int c = 0; c < 40; c++) begin
      if (c % 8 == 0) chk("idle_slot", cur_slot, c / 8);
      chk("idle_we", mem_write, 0);
      tick();
    end

    // addr=3 data=A5 at cycle 2: SHIFT at cycles 24..31, done at 32.
    do_reset();
    tick(2);
    chk("a5_ready", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = 5'd3;
    req_data  = 8'hA5;
    tick();
    req_valid = 1'b0;
    chk("a5_ready_low", req_ready, 0);
    for (int c = 3; c < 24; c++) begin
      chk("a5_wait_we", mem_write, 0);
      chk("a5_wait_busy", busy, 1);
      tick();
    end
    expect_write("a5", 8'hA5, 24);
    chk("a5_ready_back", req_ready, 1);

    // addr=0 requested mid slot-0 period: full rotation, SHIFT at 256.
    do_reset();
    tick(3);
    req_valid = 1'b1;
    req_addr  = 5'd0;
    req_data  = 8'h5E;
    tick();
    req_valid = 1'b0;
    expect_write("wrap", 8'h5E, 256);

    // Back-to-back with req_valid held: slot 5 then slot 6.
    do_reset();
    tick(1);
    req_valid = 1'b1;
    req_addr  = 5'd5;
    req_data  = 8'h96;
    tick();
    chk("b2b_ready_low", req_ready, 0);
    chk("b2b_busy", busy, 1);
    req_addr = 5'd6;
    req_data = 8'h6C;
    expect_write("b2b1", 8'h96, 40);
    chk("b2b_ready_again", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("b2b_busy2", busy, 1);
    expect_write("b2b2", 8'h6C, 304);

    // Zero-wait: request on bit 7 of slot 0 for slot 1 writes next cycle.
    do_reset();
    tick(7);
    chk("zero_ready", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = 5'd1;
    req_data  = 8'hC3;
    tick();
    req_valid = 1'b0;
    chk("zero_busy", busy, 1);
    expect_write("zero", 8'hC3, 8);

    // Reset at SHIFT bit 4 aborts the write without a done pulse.
    do_reset();
    req_valid = 1'b1;
    req_addr  = 5'd2;
    req_data  = 8'hFF;
    tick();
    req_valid = 1'b0;
    tick(19);
    chk("abort_we_before", mem_write, 1);
    chk("abort_slot_before", cur_slot, 2);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_we", mem_write, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_slot", cur_slot, 0);
    chk("abort_done", done, 0);
    tick(2);
    reset = 1'b0;
    chk("abort_rel_slot", cur_slot, 0);
    chk("abort_rel_ready", req_ready, 1);
    for (int c = 0; c < 16; c++) begin
      chk("abort_no_done", done, 0);
      chk("abort_no_we", mem_write, 0);
      tick();
    end
    chk("abort_err", err, 0);

`ifdef SERIAL_MEM_LOADER_VERIFY_EN
    // Readback: good write keeps err low, corrupted output sets it sticky.
    do_reset();
    req_valid = 1'b1;
    req_addr  = 5'd7;
    req_data  = 8'h3C;
    tick();
    req_valid = 1'b0;
    expect_write("v_ok", 8'h3C, 56);
    chk("v_ok_err", err, 0);
    chk("v_ok_ready", req_ready, 1);
    corrupt   = 8'h01;
    req_valid = 1'b1;
    req_addr  = 5'd9;
    req_data  = 8'h3C;
    tick();
    req_valid = 1'b0;
    expect_write("v_bad", 8'h3C, 72);
    chk("v_bad_err", err, 1);
    corrupt = 8'h00;
    tick(20);
    chk("v_sticky", err, 1);
    do_reset();
    chk("v_clear", err, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
